prog_loader: RTL and testbench

Program loader on the write side of instruction memory. It receives the program as a byte stream from the UART receiver and writes it into instruction memory. It assembles big-endian 32-bit words, drives the write port, and asserts `done` when the whole program is stored. The fetch/decode path reads from that memory, and `done` gates release of the CPU core.

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_if.sv | 38 +++
 rtl/prog_loader_byte_packer.sv | 35 +++
 rtl/prog_loader.sv | 143 ++++++++++++++
 tb/tb_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Build option: PROG_LOADER_CHECKSUM_EN enables the trailing checksum byte.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DONE
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader sits on the slave modport; the byte source/observer on master.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              loading;
    logic              done;
    logic              err;

    modport master (
        output rx_data,
        output rx_valid,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  loading,
        input  done,
        input  err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output loading,
        output done,
        output err
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Big-endian byte-to-word packer; word and word_valid are combinational
// on the 4th byte so the consumer can register them in the same cycle.
module byte_packer
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);
    logic [WORD_W-9:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = valid_i && (cnt_q == 2'(WORD_BYTES - 1));

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (valid_i) begin
            shift_d = word_o[WORD_W-9:0];
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
    end
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed big-endian word stream into instruction memory.
// Build option: PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 14
)(
    input logic         clk,
    input logic         rst,
    prog_loader_if.slave bus
);
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e END_ST = ST_CHK;
`else
    localparam state_e END_ST = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              pk_valid;
    logic              pk_clear;
    logic              enter_data;
    logic [WORD_W-1:0] word;
    logic              word_valid;

    // The packer serves both the count field and the data words.
    assign pk_valid = bus.rx_valid &&
                      (state_q == ST_LEN || state_q == ST_DATA);
    assign pk_clear = rst || enter_data;

    byte_packer u_packer (
        .clk          (clk),
        .clear_i      (pk_clear),
        .valid_i      (pk_valid),
        .byte_i       (bus.rx_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        enter_data = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            ST_LEN: begin
                if (word_valid) begin
                    n_d   = word;
                    idx_d = '0;
                    if ({1'b0, word} > DEPTH)
                        err_d = 1'b1;
                    if (word == '0) begin
                        state_d = END_ST;
                    end else begin
                        state_d    = ST_DATA;
                        enter_data = 1'b1;
                    end
                end
            end
            ST_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (bus.rx_valid)
                    csum_d = csum_q ^ bus.rx_data;
`endif
                if (word_valid) begin
                    // Words past the memory depth are consumed, not written.
                    if ({1'b0, idx_q} < DEPTH) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = word;
                    end
                    idx_d = idx_q + 32'd1;
                    if (idx_q == n_q - 32'd1)
                        state_d = END_ST;
                end
            end
            ST_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (bus.rx_valid) begin
                    state_d = ST_DONE;
                    if (bus.rx_data != csum_q)
                        err_d = 1'b1;
                end
`endif
            end
            default: ;
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LEN;
            n_q     <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.loading    = (state_q != ST_DONE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a deep (ADDR_W=14) and a shallow
// (ADDR_W=2) instance share one byte stream; writes are logged per instance.
module tb_prog_loader;
    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;

    int n_pass;
    int n_total;

    logic [31:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [31:0] qb_addr[$];
    logic [31:0] qb_data[$];

    prog_loader_if #(.ADDR_W(14)) bus_a();
    prog_loader_if #(.ADDR_W(2))  bus_b();

    assign bus_a.rx_data  = rx_data;
    assign bus_a.rx_valid = rx_valid;
    assign bus_b.rx_data  = rx_data;
    assign bus_b.rx_valid = rx_valid;

    prog_loader #(.ADDR_W(14)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    prog_loader #(.ADDR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_a.imem_we === 1'b1) begin
            qa_addr.push_back(32'(bus_a.imem_addr));
            qa_data.push_back(bus_a.imem_wdata);
        end
        if (bus_b.imem_we === 1'b1) begin
            qb_addr.push_back(32'(bus_b.imem_addr));
            qb_data.push_back(bus_b.imem_wdata);
        end
    end

    task automatic clear_logs();
        qa_addr.delete();
        qa_data.delete();
        qb_addr.delete();
        qb_data.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--)
            send(w[i*8 +: 8], gap);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        clear_logs();
        n_total++; if (bus_a.imem_we !== 1'b0) $display("FAIL rst_we got=%0b exp=0", bus_a.imem_we); else n_pass++;
        n_total++; if (bus_a.imem_addr !== 14'd0) $display("FAIL rst_addr got=%0h exp=0", bus_a.imem_addr); else n_pass++;
        n_total++; if (bus_a.imem_wdata !== 32'd0) $display("FAIL rst_wdata got=%0h exp=0", bus_a.imem_wdata); else n_pass++;
        n_total++; if (bus_a.loading !== 1'b1) $display("FAIL rst_loading got=%0b exp=1", bus_a.loading); else n_pass++;
        n_total++; if (bus_a.done !== 1'b0) $display("FAIL rst_done got=%0b exp=0", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", bus_a.err); else n_pass++;
        n_total++; if (bus_b.err !== 1'b0) $display("FAIL rst_err_b got=%0b exp=0", bus_b.err); else n_pass++;
    endtask

    task automatic test_n3();
        logic [31:0] w[3];
        logic [31:0] a;
        w[0] = 32'h20010005;
        w[1] = 32'h00221820;
        w[2] = 32'hFC000000;
        do_reset();
        send_word(32'd3, 0);
        send_word(w[0], 0);
        send_word(w[1], 0);
        send(8'hFC, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        n_total++; if (bus_a.done !== 1'b0) $display("FAIL n3_done_early got=%0b exp=0", bus_a.done); else n_pass++;
        send(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        n_total++; if (bus_a.done !== 1'b0) $display("FAIL n3_done_pre_chk got=%0b exp=0", bus_a.done); else n_pass++;
        send(8'hC2, 0);
`else
        n_total++; if (bus_a.imem_we !== 1'b1) $display("FAIL n3_we_with_done got=%0b exp=1", bus_a.imem_we); else n_pass++;
        n_total++; if (bus_a.imem_wdata !== 32'hFC000000) $display("FAIL n3_last_wdata got=%0h exp=fc000000", bus_a.imem_wdata); else n_pass++;
`endif
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL n3_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.loading !== 1'b0) $display("FAIL n3_loading got=%0b exp=0", bus_a.loading); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL n3_err got=%0b exp=0", bus_a.err); else n_pass++;
        settle();
        n_total++; if (qa_addr.size() !== 3) $display("FAIL n3_nwrites got=%0d exp=3", qa_addr.size()); else n_pass++;
        n_total++; if (qb_addr.size() !== 3) $display("FAIL n3_nwrites_b got=%0d exp=3", qb_addr.size()); else n_pass++;
        for (int i = 0; i < 3 && i < qa_addr.size(); i++) begin
            a = 32'(i);
            n_total++; if (qa_addr[i] !== a) $display("FAIL n3_addr%0d got=%0h exp=%0h", i, qa_addr[i], a); else n_pass++;
            n_total++; if (qa_data[i] !== w[i]) $display("FAIL n3_data%0d got=%0h exp=%0h", i, qa_data[i], w[i]); else n_pass++;
        end
    endtask

    task automatic test_n0();
        do_reset();
        send_word(32'd0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        n_total++; if (bus_a.done !== 1'b0) $display("FAIL n0_done_pre_chk got=%0b exp=0", bus_a.done); else n_pass++;
        send(8'h00, 0);
`endif
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL n0_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL n0_err got=%0b exp=0", bus_a.err); else n_pass++;
        settle();
        n_total++; if (qa_addr.size() !== 0) $display("FAIL n0_nwrites got=%0d exp=0", qa_addr.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] w[5];
        logic [31:0] a;
        w[0] = 32'h11111111;
        w[1] = 32'h22222222;
        w[2] = 32'h33333333;
        w[3] = 32'h44444444;
        w[4] = 32'h55555555;
        do_reset();
        send_word(32'd5, 0);
        n_total++; if (bus_b.err !== 1'b1) $display("FAIL ovf_err_b got=%0b exp=1", bus_b.err); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL ovf_err_a got=%0b exp=0", bus_a.err); else n_pass++;
        for (int i = 0; i < 5; i++)
            send_word(w[i], 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h00, 0);
`endif
        n_total++; if (bus_b.done !== 1'b1) $display("FAIL ovf_done_b got=%0b exp=1", bus_b.done); else n_pass++;
        n_total++; if (bus_b.err !== 1'b1) $display("FAIL ovf_err_end_b got=%0b exp=1", bus_b.err); else n_pass++;
        n_total++; if (bus_b.imem_addr !== 2'd3) $display("FAIL ovf_addr_hold_b got=%0h exp=3", bus_b.imem_addr); else n_pass++;
        settle();
        n_total++; if (qb_addr.size() !== 4) $display("FAIL ovf_nwrites_b got=%0d exp=4", qb_addr.size()); else n_pass++;
        n_total++; if (qa_addr.size() !== 5) $display("FAIL ovf_nwrites_a got=%0d exp=5", qa_addr.size()); else n_pass++;
        for (int i = 0; i < 4 && i < qb_addr.size(); i++) begin
            a = 32'(i);
            n_total++; if (qb_addr[i] !== a) $display("FAIL ovf_addr%0d got=%0h exp=%0h", i, qb_addr[i], a); else n_pass++;
            n_total++; if (qb_data[i] !== w[i]) $display("FAIL ovf_data%0d got=%0h exp=%0h", i, qb_data[i], w[i]); else n_pass++;
        end
        if (qa_addr.size() == 5) begin
            n_total++; if (qa_addr[4] !== 32'd4) $display("FAIL ovf_addr4_a got=%0h exp=4", qa_addr[4]); else n_pass++;
        end
    endtask

    task automatic test_restart_gaps();
        int g;
        g = 0;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            send(8'(32'd2 >> (i*8)), g % 8);
            g++;
        end
        send_word(32'h0BADF00D, 1);
        send(8'h12, 3);
        send(8'h34, 2);
        n_total++; if (qa_addr.size() !== 1) $display("FAIL rs_prewrite got=%0d exp=1", qa_addr.size()); else n_pass++;
        // byte presented during reset must be dropped
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h56;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        clear_logs();
        n_total++; if (bus_a.loading !== 1'b1) $display("FAIL rs_loading got=%0b exp=1", bus_a.loading); else n_pass++;
        for (int i = 3; i >= 0; i--) begin
            send(8'(32'd1 >> (i*8)), g % 8);
            g++;
        end
        send(8'hDE, g % 8); g++;
        send(8'hAD, g % 8); g++;
        send(8'hBE, g % 8); g++;
        send(8'hEF, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h22, 0);
`endif
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL rs_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL rs_err got=%0b exp=0", bus_a.err); else n_pass++;
        settle();
        n_total++; if (qa_addr.size() !== 1) $display("FAIL rs_nwrites got=%0d exp=1", qa_addr.size()); else n_pass++;
        if (qa_addr.size() == 1) begin
            n_total++; if (qa_addr[0] !== 32'd0) $display("FAIL rs_addr got=%0h exp=0", qa_addr[0]); else n_pass++;
            n_total++; if (qa_data[0] !== 32'hDEADBEEF) $display("FAIL rs_data got=%0h exp=deadbeef", qa_data[0]); else n_pass++;
        end
    endtask

    task automatic test_after_done();
        clear_logs();
        for (int i = 0; i < 10; i++)
            send(8'($urandom_range(0, 255)), 0);
        settle();
        n_total++; if (qa_addr.size() !== 0) $display("FAIL ad_nwrites got=%0d exp=0", qa_addr.size()); else n_pass++;
        n_total++; if (qb_addr.size() !== 0) $display("FAIL ad_nwrites_b got=%0d exp=0", qb_addr.size()); else n_pass++;
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL ad_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL ad_err got=%0b exp=0", bus_a.err); else n_pass++;
        n_total++; if (bus_a.loading !== 1'b0) $display("FAIL ad_loading got=%0b exp=0", bus_a.loading); else n_pass++;
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h01020304, 0);
        send(8'h04, 0);
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL ck_ok_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL ck_ok_err got=%0b exp=0", bus_a.err); else n_pass++;
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h01020304, 0);
        n_total++; if (bus_a.err !== 1'b0) $display("FAIL ck_bad_err_early got=%0b exp=0", bus_a.err); else n_pass++;
        send(8'h05, 0);
        n_total++; if (bus_a.done !== 1'b1) $display("FAIL ck_bad_done got=%0b exp=1", bus_a.done); else n_pass++;
        n_total++; if (bus_a.err !== 1'b1) $display("FAIL ck_bad_err got=%0b exp=1", bus_a.err); else n_pass++;
    endtask
`endif

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_n3();
        test_n0();
        test_overflow();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_restart_gaps();
        test_after_done();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
